// File: rtl/if_fetch_queue.sv
// if_fetch_queue: decoupled instruction fetch front end for the 5-stage MIPS pipe.
//
// The block issues word fetches to a variable-latency instruction memory and
// buffers the in-order responses in a DEPTH-entry queue. The queue head drives
// the IF/ID register as {PC+4, instruction}. A branch redirect flushes the queue
// and marks every in-flight response as stale, so those responses are dropped
// when they arrive.
//
// Ports:
//   clk, rst              clock (rising edge), async active-low reset
//   imem_req_valid/ready  fetch request handshake
//   imem_req_addr         word-aligned fetch address
//   imem_rsp_valid/data   in-order fetch response
//   redirect, redirect_pc taken branch from MEM and its target
//   id_stall              IF/ID cannot accept this cycle
//   id_valid/pc4/instr    queue head (PC+4 and instruction; zeros when empty)
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_pc4,
  output logic [31:0] id_instr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } entry_t;

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  rsp_pc_q,   rsp_pc_d;
  logic [CW-1:0] out_q,     out_d;     // requests accepted, response not yet seen
  logic [CW-1:0] disc_q,    disc_d;    // stale responses still to be dropped
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
  entry_t [DEPTH-1:0] q_mem_q;

  logic [CW-1:0] inflight;
  logic          accept, push, pop;
  logic [31:0]   redir_al;

  // Low PC bits are forced to zero everywhere; keep them visible to lint.
  logic unused_lowbits;
  assign unused_lowbits = ^{redirect_pc[1:0], fetch_pc_q[1:0]};

  assign redir_al = {redirect_pc[31:2], 2'b00};

  // Gate on outstanding + queued so every response always has a free slot.
  assign inflight       = out_q + cnt_q;
  assign imem_req_valid = rst && !redirect && (inflight < CW'(DEPTH));
  assign imem_req_addr  = {fetch_pc_q[31:2], 2'b00};

  assign accept = imem_req_valid && imem_req_ready;
  assign push   = imem_rsp_valid && (disc_q == '0) && !redirect;
  assign pop    = id_valid && !id_stall && !redirect;

  assign id_valid = (cnt_q != '0);
  assign id_pc4   = id_valid ? q_mem_q[rd_ptr_q].pc4   : 32'h0;
  assign id_instr = id_valid ? q_mem_q[rd_ptr_q].instr : 32'h0;

  // In-flight count after this cycle; also the stale count loaded on redirect.
  assign out_d = out_q + CW'(accept) - CW'(imem_rsp_valid);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    disc_d     = disc_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect) begin
      fetch_pc_d = redir_al;
      rsp_pc_d   = redir_al;
      disc_d     = out_d;
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (accept)
        fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rsp_valid && (disc_q != '0))
        disc_d = disc_q - CW'(1);
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while the queue is empty.
  always_ff @(posedge clk) begin
    if (push)
      q_mem_q[wr_ptr_q] <= '{pc4: rsp_pc_q + 32'd4, instr: imem_rsp_data};
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: in-order memory model with per-request latency,
// plus a reference model of the instruction stream the ID stage must see.
module tb_if_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_stall = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc4, id_instr;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_stall(id_stall),
    .id_valid(id_valid), .id_pc4(id_pc4), .id_instr(id_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;
  typedef struct {
    logic [31:0] pc4;
    logic [31:0] instr;
  } ent_t;

  req_t        pend[$];   // accepted requests awaiting their response
  ent_t        mq[$];     // instructions the ID stage should see, in order
  logic [31:0] fpc = RESET_PC;
  int          cyc = 0;
  int          lat_lo = 1, lat_hi = 1;
  bit          exp_rv;
  int          checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mq.delete();
    fpc = RESET_PC;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'hA500_0000;
  endfunction

  // Apply this cycle's inputs away from the edge, then compare against the model.
  task automatic drive(input bit redir, input logic [31:0] rpc, input bit stall, input bit rdy);
    @(negedge clk);
    redirect = redir; redirect_pc = rpc; id_stall = stall; imem_req_ready = rdy;
    if (rst && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    assert (!imem_rsp_valid || pend.size() > 0);
    exp_rv = rst && !redir && ((pend.size() + mq.size()) < DEPTH);
    chk("req_valid", {31'h0, imem_req_valid}, {31'h0, exp_rv});
    chk("req_addr", imem_req_addr, fpc);
    chk("id_valid", {31'h0, id_valid}, {31'h0, mq.size() != 0});
    chk("id_pc4", id_pc4, (mq.size() != 0) ? mq[0].pc4 : 32'h0);
    chk("id_instr", id_instr, (mq.size() != 0) ? mq[0].instr : 32'h0);
  endtask

  // Advance the model by what happens at the coming rising edge.
  task automatic tick();
    bit   pop_c, acc;
    req_t r;
    if (rst) begin
      acc   = exp_rv && imem_req_ready;
      pop_c = !redirect && mq.size() > 0 && !id_stall;
      if (pop_c) void'(mq.pop_front());
      if (imem_rsp_valid) begin
        r = pend.pop_front();
        if (!redirect && !r.stale)
          mq.push_back('{pc4: r.addr + 32'd4, instr: imem_rsp_data});
      end
      if (redirect) begin
        mq.delete();
        foreach (pend[i]) pend[i].stale = 1'b1;
        fpc = redirect_pc & ~32'h3;
      end
      if (acc) begin
        pend.push_back('{addr: fpc, due: cyc + int'($urandom_range(lat_hi, lat_lo)), stale: 1'b0});
        fpc = fpc + 32'd4;
      end
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc, input bit stall, input bit rdy);
    drive(redir, rpc, stall, rdy);
    tick();
  endtask

  // Run until the head is valid (bounded), leaving inputs driven for that cycle.
  task automatic wait_head(input string name, input int bound);
    int n = 0;
    drive(0, 0, 0, 1);
    while (!id_valid && n < bound) begin
      tick();
      drive(0, 0, 0, 1);
      n++;
    end
    if (!id_valid) begin
      checks++; failures++;
      $display("FAIL %s timeout got=id_valid 0 exp=id_valid 1", name);
    end
  endtask

  initial begin
    int got_n;
    logic [31:0] e;
    // ---- reset ----
    model_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    #2 rst = 1'b1;

    // ---- 1: streaming, 1-cycle latency ----
    lat_lo = 1; lat_hi = 1;
    drive(0, 0, 0, 1);
    chk("t1_first_addr", imem_req_addr, 32'h0);
    chk("t1_first_rv", {31'h0, imem_req_valid}, 32'h1);
    tick();
    drive(0, 0, 0, 1);
    chk("t1_no_bypass", {31'h0, id_valid}, 32'h0);
    tick();
    drive(0, 0, 0, 1);
    chk("t1_first_valid", {31'h0, id_valid}, 32'h1);
    chk("t1_first_pc4", id_pc4, 32'h4);
    chk("t1_first_instr", id_instr, 32'hA500_0000);
    tick();
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

    // ---- 2: back-pressure from ID ----
    step(1, 32'h0, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1);
    drive(0, 0, 1, 1);
    chk("t2_full_rv", {31'h0, imem_req_valid}, 32'h0);
    chk("t2_full_head", id_pc4, 32'h4);
    tick();
    got_n = 0; e = 32'h4;
    for (int i = 0; i < 40 && got_n < 5; i++) begin
      drive(0, 0, 0, 1);
      if (id_valid) begin
        chk("t2_order_pc4", id_pc4, e);
        e += 4; got_n++;
      end
      tick();
    end
    chk("t2_popped", got_n, 5);

    // ---- 3: redirect with 2 stale responses in flight ----
    lat_lo = 3; lat_hi = 3;
    step(1, 32'h200, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 32'h40, 0, 1);
    wait_head("t3_head", 20);
    chk("t3_pc4", id_pc4, 32'h44);
    chk("t3_instr", id_instr, 32'hA500_0040);
    tick();

    // ---- 4: redirect + response + pop in one cycle ----
    lat_lo = 1; lat_hi = 1;
    step(1, 32'h300, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    drive(1, 32'h500, 0, 1);
    chk("t4_pre_valid", {31'h0, id_valid}, 32'h1);
    chk("t4_pre_pc4", id_pc4, 32'h304);
    tick();
    drive(0, 0, 0, 1);
    chk("t4_flushed", {31'h0, id_valid}, 32'h0);
    tick();
    wait_head("t4_head", 20);
    chk("t4_next_pc4", id_pc4, 32'h504);
    tick();

    // ---- 5: misaligned target ----
    step(1, 32'h0000_0046, 0, 1);
    drive(0, 0, 0, 1);
    chk("t5_addr", imem_req_addr, 32'h44);
    tick();
    wait_head("t5_head", 20);
    chk("t5_pc4", id_pc4, 32'h48);
    tick();

    // ---- 6: ready held low, then async reset mid-stream ----
    step(1, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0);
      chk("t6_hold_addr", imem_req_addr, 32'h8);
      tick();
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
    #2 chk("t6_pre_valid", {31'h0, id_valid}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_rv", {31'h0, imem_req_valid}, 32'h0);
    chk("t6_rst_idv", {31'h0, id_valid}, 32'h0);
    chk("t6_rst_pc4", id_pc4, 32'h0);
    chk("t6_rst_instr", id_instr, 32'h0);
    model_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    #2 rst = 1'b1;
    drive(0, 0, 0, 1);
    chk("t6_restart_addr", imem_req_addr, RESET_PC);
    tick();

    // ---- random traffic ----
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      bit          rd;
      logic [31:0] tgt;
      rd  = ($urandom_range(19, 0) == 0);
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(rd, tgt, $urandom_range(2, 0) == 0, $urandom_range(3, 0) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Instruction fetch front end for the 5-stage MIPS pipeline. It replaces the bare PC register and PC+4 adder with a decoupled fetch engine. The engine issues word fetches to a variable-latency instruction memory over a valid/ready interface and buffers in-order responses in a small queue. The queue head feeds the IF/ID register as {PC+4, instruction}. A branch redirect from the MEM stage flushes the queue and discards any responses still in flight.

Parameters:
DEPTH, 4, queue entries; also the cap on requests outstanding plus entries queued (power of 2, 2..16)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts the request this cycle
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance
imem_rsp_data  in  32  fetched instruction
redirect  in  1  branch taken (PCSrc from MEM stage)
redirect_pc  in  32  branch target
id_stall  in  1  IF/ID cannot accept this cycle
id_valid  out  1  queue head valid
id_pc4  out  32  PC+4 of the head instruction
id_instr  out  32  head instruction

Behaviour:
- Reset (rst=0, asynchronous) clears all state:
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - outstanding=0, discard_cnt=0, queue count=0, read/write pointers=0.
  - Outputs while in reset: imem_req_valid=0, id_valid=0, id_pc4=0, id_instr=0.
- Request side:
  - imem_req_valid = !redirect && (outstanding + count) < DEPTH. This is combinational from state and redirect.
  - imem_req_addr = {fetch_pc[31:2], 2'b00}.
  - On accept (valid && ready): fetch_pc += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0), and outstanding += 1.
  - While valid && !ready and no redirect, the address holds stable.
- Response side, on imem_rsp_valid:
  - outstanding -= 1.
  - If discard_cnt != 0: discard_cnt -= 1 and drop the data.
  - Otherwise push {rsp_pc+4, imem_rsp_data} and set rsp_pc += 4.
  - By construction the queue is never full on a push. Receiving a response with outstanding=0 is illegal; the bench asserts this never happens.
- Output side:
  - id_valid = (count != 0).
  - id_pc4 and id_instr come from the head entry, registered storage with no bypass.
  - When count=0, id_pc4=0 and id_instr=0 (NOP).
  - Pop when id_valid && !id_stall.
  - Minimum latency from response to id_valid is 1 cycle.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority; overrides push, pop and request):
  - fetch_pc and rsp_pc <= {redirect_pc[31:2], 2'b00}. Misaligned low bits are silently zeroed.
  - Queue cleared: count=0, pointers reset.
  - discard_cnt <= outstanding_next, the in-flight count after this cycle. A response arriving in the redirect cycle is dropped and is not counted in discard_cnt.
  - id_valid=0 in the following cycle.
  - The first new request goes out in the cycle after the redirect.
- A redirect while discard_cnt != 0: discard_cnt is reloaded with outstanding_next. This stays correct because every in-flight response is stale.
- Counters are sized $clog2(DEPTH)+1 bits. No overflow is possible given the request gating.
- Reset mid-operation: all in-flight state is abandoned. The memory model must also be reset by the same rst.

Test Plan:
1. Reset, then release; ready=1, 1-cycle response latency, data=addr|32'hA500_0000, id_stall=0. Required: addresses 0,4,8,... issue; id_pc4 = 4,8,12,... with matching instr; first id_valid 2 cycles after the first accept.
2. id_stall=1 for 20 cycles. Required: count + outstanding never exceeds 4; req_valid drops once 4 are reached. After release, id_pc4 = 4,8,12,16,20 in order with no loss or duplication.
3. 3-cycle response latency; redirect to 0x40 while 2 requests are in flight. Required: both stale responses are dropped; the next id_valid presents id_pc4=0x44, id_instr=0xA500_0040.
4. Redirect, imem_rsp_valid and pop all in the same cycle, with 1 entry queued. Required: next cycle id_valid=0, and the response is not pushed.
5. redirect_pc=0x0000_0046. Required: fetch address 0x44; id_pc4=0x48.
6. imem_req_ready=0 for 3 cycles. Required: addr held at 0x8 and fetch_pc unchanged. Then pull rst low between clock edges mid-stream. Required: id_valid and imem_req_valid go 0 immediately; after release, fetch restarts at RESET_PC.
